change_dispenser: RTL and testbench

Sequences coin change-out after a vending transaction. It takes the change amount computed by the transaction state machine (the same 8-bit value shown on the display as change money) and decomposes it greedily into 50/20/10/5/1 coins. It drives a one-hot eject request per coin to the hopper and waits for the hopper's acknowledge. It also keeps a per-denomination coin inventory, fed by debounced customer coin-insert pulses, so it never requests a coin it does not hold.

---
 rtl/change_dispenser.sv | 191 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: greedy coin change-out sequencer with per-denomination
// inventory. Denomination order (bit 0..4) is 1, 5, 10, 20, 50.
// Optional build macro: CHANGE_ACK_TIMEOUT_EN enables the eject acknowledge
// timeout. Without it, EJECT waits indefinitely and fault stays 0.
//
// state  | meaning
// IDLE   | waiting for start
// SELECT | choose the largest affordable denomination that is in stock
// EJECT  | hold one-hot eject until the hopper acknowledges
// GAP    | settle time after an acknowledge before the next selection
// DONE   | one-cycle done pulse, results held
module change_dispenser #(
  parameter int STOCK_W     = 4,
  parameter int STOCK_INIT  = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 1000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       start,
  input  logic [7:0] change_amount,
  input  logic [4:0] deposit,
  input  logic       eject_ack,
  output logic [4:0] eject,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic       fault,
  output logic [7:0] remaining,
  output logic [4:0] stock_empty
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [STOCK_W-1:0] STOCK_MAX = {STOCK_W{1'b1}};

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_EJECT, S_GAP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         rem_q, rem_d;
  logic [2:0]         sel_q, sel_d;
  logic               short_q, short_d;
  logic               fault_q, fault_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [4:0]         eject_q, eject_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [4:0]         empty_q, empty_d;
  logic [STOCK_W-1:0] stock_q [5];
  logic [STOCK_W-1:0] stock_d [5];
  logic [4:0]         dec;
  logic               pick_ok;
  logic [2:0]         pick_idx;

  function automatic logic [7:0] coin_val(input logic [2:0] idx);
    case (idx)
      3'd0:    coin_val = 8'd1;
      3'd1:    coin_val = 8'd5;
      3'd2:    coin_val = 8'd10;
      3'd3:    coin_val = 8'd20;
      default: coin_val = 8'd50;
    endcase
  endfunction

  // Largest denomination that fits the amount owed and is in stock.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = 3'd0;
    for (int k = 0; k < 5; k++) begin
      if (coin_val(3'(k)) <= rem_q && stock_q[k] != '0) begin
        pick_ok  = 1'b1;
        pick_idx = 3'(k);
      end
    end
  end

  // Next-state logic and registered-output precompute.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    short_d = short_q;
    fault_d = fault_q;
    gap_d   = gap_q;
    tmr_d   = tmr_q;
    dec     = 5'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = change_amount;
          short_d = 1'b0;
          fault_d = 1'b0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (rem_q == 8'd0) begin
          state_d = S_DONE;
        end else if (pick_ok) begin
          sel_d   = pick_idx;
          tmr_d   = TMR_W'(ACK_TIMEOUT - 1);
          state_d = S_EJECT;
        end else begin
          short_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_EJECT: begin
        if (eject_ack) begin
          rem_d      = rem_q - coin_val(sel_q);
          dec[sel_q] = 1'b1;
          gap_d      = GAP_W'(GAP_CYCLES);
          state_d    = S_GAP;
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - 1'b1;
        end
`ifdef CHANGE_ACK_TIMEOUT_EN
        else begin
          fault_d = 1'b1;
          short_d = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_SELECT;
        else             gap_d   = gap_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    eject_d = (state_d == S_EJECT) ? (5'b00001 << sel_d) : 5'b0;
    busy_d  = (state_d == S_SELECT) || (state_d == S_EJECT) || (state_d == S_GAP);
    done_d  = (state_d == S_DONE);
  end

  // Inventory: deposit increments (saturating), acknowledge decrements; both cancel.
  always_comb begin
    stock_d = stock_q;
    empty_d = 5'b0;
    for (int k = 0; k < 5; k++) begin
      if (deposit[k] && !dec[k]) begin
        if (stock_q[k] != STOCK_MAX) stock_d[k] = stock_q[k] + 1'b1;
      end else if (!deposit[k] && dec[k]) begin
        stock_d[k] = stock_q[k] - 1'b1;
      end
      empty_d[k] = (stock_d[k] == '0);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      rem_q   <= 8'd0;
      sel_q   <= 3'd0;
      short_q <= 1'b0;
      fault_q <= 1'b0;
      gap_q   <= '0;
      tmr_q   <= '0;
      eject_q <= 5'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      empty_q <= (STOCK_INIT == 0) ? 5'b11111 : 5'b00000;
      for (int k = 0; k < 5; k++) stock_q[k] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      short_q <= short_d;
      fault_q <= fault_d;
      gap_q   <= gap_d;
      tmr_q   <= tmr_d;
      eject_q <= eject_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      empty_q <= empty_d;
      stock_q <= stock_d;
    end
  end

  assign eject       = eject_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign short       = short_q;
  assign fault       = fault_q;
  assign remaining   = rem_q;
  assign stock_empty = empty_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: greedy order, shortfall, inventory
// saturation/cancel, zero-amount timing, reset abort, optional ack timeout.
module tb_change_dispenser;

  localparam int GAP = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] change_amount = 8'd0;
  logic [4:0] deposit = 5'b0;
  logic       eject_ack = 1'b0;
  logic [4:0] eject;
  logic       busy, done, short, fault;
  logic [7:0] remaining;
  logic [4:0] stock_empty;

  logic       start1 = 1'b0;
  logic [7:0] amount1 = 8'd0;
  logic       ack1 = 1'b0;
  logic [4:0] eject1;
  logic       busy1, done1, short1, fault1;
  logic [7:0] remaining1;
  logic [4:0] stock_empty1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 sys_clk = ~sys_clk;

  change_dispenser #(.STOCK_W(4), .STOCK_INIT(8), .GAP_CYCLES(GAP), .ACK_TIMEOUT(20)) u_dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .change_amount(change_amount),
    .deposit(deposit), .eject_ack(eject_ack), .eject(eject), .busy(busy), .done(done),
    .short(short), .fault(fault), .remaining(remaining), .stock_empty(stock_empty)
  );

  change_dispenser #(.STOCK_W(4), .STOCK_INIT(1), .GAP_CYCLES(GAP), .ACK_TIMEOUT(20)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start1), .change_amount(amount1),
    .deposit(5'b0), .eject_ack(ack1), .eject(eject1), .busy(busy1), .done(done1),
    .short(short1), .fault(fault1), .remaining(remaining1), .stock_empty(stock_empty1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
  endtask

  // Wait for an eject, check it, acknowledge it (optionally with a deposit).
  task automatic pay_coin(input string tag, input logic [4:0] exp_ej, input logic [7:0] exp_rem,
                          input bit after_ack, input logic [4:0] dep);
    int n = 0;
    while (eject == 5'b0 && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_eject"}, eject, exp_ej);
    if (after_ack) chk({tag, "_gap_ok"}, (n >= GAP + 2), 1);
    eject_ack = 1'b1;
    deposit   = dep;
    step();
    eject_ack = 1'b0;
    deposit   = 5'b0;
    chk({tag, "_eject_drop"}, eject, 5'b0);
    chk({tag, "_remaining"}, remaining, exp_rem);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
  endtask

  initial begin
    logic [4:0] got [8];
    logic [4:0] exp1 [5];
    int         n;

    // Reset state
    do_reset();
    chk("rst_outputs", {eject, busy, done, short, fault, remaining}, 0);
    chk("rst_stock_empty", stock_empty, 0);
    chk("rst_stock50", u_dut.stock_q[4], 8);

    // 76 -> 50, 20, 5, 1
    change_amount = 8'd76;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t76_busy_t1", busy, 1);
    chk("t76_eject_t1", eject, 0);
    step();
    chk("t76_eject_t2", eject, 5'b10000);
    pay_coin("t76_c50", 5'b10000, 8'd26, 1'b0, 5'b0);
    pay_coin("t76_c20", 5'b01000, 8'd6, 1'b1, 5'b0);
    pay_coin("t76_c5", 5'b00010, 8'd1, 1'b1, 5'b0);
    pay_coin("t76_c1", 5'b00001, 8'd0, 1'b1, 5'b0);
    wait_done("t76");
    chk("t76_short", short, 0);
    chk("t76_fault", fault, 0);
    chk("t76_stock50", u_dut.stock_q[4], 7);
    chk("t76_stock20", u_dut.stock_q[3], 7);
    chk("t76_stock10", u_dut.stock_q[2], 8);
    chk("t76_stock5", u_dut.stock_q[1], 7);
    chk("t76_stock1", u_dut.stock_q[0], 7);
    step();
    chk("t76_done_pulse", done, 0);
    chk("t76_rem_hold", remaining, 0);

    // STOCK_INIT=1 instance, 100 -> 50, 20, 10, 5, 1, short with 14 left
    do_reset();
    exp1 = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    amount1 = 8'd100;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    n = 0;
    for (int c = 0; c < 400 && !done1; c++) begin
      if (eject1 != 5'b0 && n < 8) begin
        got[n] = eject1;
        n++;
        ack1 = 1'b1;
        step();
        ack1 = 1'b0;
      end else begin
        step();
      end
    end
    chk("s1_done", done1, 1);
    chk("s1_coin_count", n, 5);
    for (int i = 0; i < 5; i++) chk($sformatf("s1_order%0d", i), got[i], exp1[i]);
    chk("s1_remaining", remaining1, 14);
    chk("s1_short", short1, 1);
    chk("s1_stock_empty", stock_empty1, 5'b11111);

    // Deposit on the acknowledge edge cancels; saturation at 15
    do_reset();
    change_amount = 8'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    pay_coin("dep_c5", 5'b00010, 8'd0, 1'b0, 5'b00010);
    chk("dep_cancel_stock5", u_dut.stock_q[1], 8);
    wait_done("dep");
    chk("dep_short", short, 0);
    for (int i = 0; i < 7; i++) begin
      deposit = 5'b00010;
      step();
    end
    deposit = 5'b0;
    chk("dep_fill_stock5", u_dut.stock_q[1], 15);
    deposit = 5'b00010;
    step();
    deposit = 5'b0;
    chk("dep_sat_stock5", u_dut.stock_q[1], 15);
    deposit = 5'b10101;
    step();
    deposit = 5'b0;
    chk("dep_multi_stock50", u_dut.stock_q[4], 9);
    chk("dep_multi_stock10", u_dut.stock_q[2], 9);
    chk("dep_multi_stock1", u_dut.stock_q[0], 9);
    chk("dep_multi_stock20", u_dut.stock_q[3], 8);

    // Zero amount
    change_amount = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_busy_t1", busy, 1);
    chk("zero_done_t1", done, 0);
    chk("zero_eject_t1", eject, 0);
    step();
    chk("zero_done_t2", done, 1);
    chk("zero_busy_t2", busy, 0);
    chk("zero_eject_t2", eject, 0);
    chk("zero_short", short, 0);
    step();
    chk("zero_done_t3", done, 0);

`ifdef CHANGE_ACK_TIMEOUT_EN
    // Acknowledge timeout
    do_reset();
    change_amount = 8'd50;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n = 0;
    while (eject[4] && n < 100) begin
      n++;
      step();
    end
    chk("to_eject_cycles", n, 20);
    chk("to_eject_low", eject, 0);
    chk("to_fault", fault, 1);
    chk("to_short", short, 1);
    chk("to_remaining", remaining, 50);
    chk("to_done", done, 1);
    chk("to_stock50", u_dut.stock_q[4], 8);
`else
    chk("no_to_fault", fault, 0);
`endif

    // Reset during eject of a 20 coin, then a clean 20 payout
    do_reset();
    change_amount = 8'd20;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("rab_eject_pre", eject, 5'b01000);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    chk("rab_outputs", {eject, busy, done, short, fault, remaining}, 0);
    chk("rab_stock_empty", stock_empty, 0);
    chk("rab_state_idle", 32'(u_dut.state_q), 0);
    for (int k = 0; k < 5; k++) chk($sformatf("rab_stock%0d", k), u_dut.stock_q[k], 8);
    change_amount = 8'd20;
    start = 1'b1;
    step();
    start = 1'b0;
    pay_coin("rab_c20", 5'b01000, 8'd0, 1'b0, 5'b0);
    wait_done("rab");
    chk("rab_short", short, 0);
    chk("rab_stock20", u_dut.stock_q[3], 7);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
